sd_itf: RTL and testbench
=========================

# sd_itf

Serial driver for a 6-digit, common-anode 7-segment display behind two cascaded 74HC595 shift registers. It holds the six 4-bit digit values, decimal points and blink mask captured on `valid_sd`. It scans the digits one at a time, sending a 14-bit frame (segments plus digit select) on `ds`/`shcp`/`stcp` for each slot. It sits between the clock/time core and the display pins.

## Interface
- `SCAN_CYC`, default 50000: sysclk cycles per digit slot (1 ms at 50 MHz). Must be ≥ 64.
- `BLINK_CYC`, default 25000000: sysclk cycles per blink half-period (0.5 s).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `sysclk` in 1: system clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous reset, active-high (asserted when 1), despite the legacy name.
- `valid_sd` in 1: load strobe. Captures `num1`..`num6`, `dp` and `twinkle` on a clock edge where it is high.
- `twinkle` in 6: blink mask. Bit k applies to digit k+1.
- `dp` in 6: decimal-point enable. Bit k lights the DP of digit k+1.
- `num6`..`num1` in 4 each: digit values in hex. `num1` is the rightmost digit.
- `stcp` out 1: 74HC595 storage (latch) clock.
- `shcp` out 1: 74HC595 shift clock.
- `ds` out 1: serial data.

## Operation
- Shadow registers hold the nums, `dp` and `twinkle`. They reset to 0 and load whenever `valid_sd`=1; holding `valid_sd` high reloads every cycle. The display uses only the shadow values.
- Digit index `d` cycles 0→5→0, advancing once per `SCAN_CYC` cycles. It resets to 0.
- Blink phase toggles every `BLINK_CYC` cycles and resets to 0 (visible).
- Segment byte `seg[7:0]` = {dp, g, f, e, d, c, b, a}, all bits active-low.
- Decode table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- DP: when `dp[d]`=1, clear `seg[7]`.
- Blanking: when `twinkle[d]`=1 and blink phase=1, `seg` = FF (DP also off).
- Select `sel[5:0]` is one-hot, active-high, with `sel[d]`=1.
- Frame = {`seg[7:0]`, `sel[5:0]`}, 14 bits, shifted MSB first (`seg[7]` first, `sel[0]` last).
- The frame is snapshotted at slot cycle 0. A load or blink change during a frame takes effect in the next slot.

## Timing
- Each slot starts at slot counter 0 and uses its first 60 cycles for the transfer. The line then idles until the slot ends.
- Bit i (i=0..13) occupies cycles 4i..4i+3.
  - `ds` is updated at cycle 4i.
  - `shcp`=0 during cycles 4i and 4i+1, and 1 during cycles 4i+2 and 4i+3.
  - The rising `shcp` edge is 2 cycles after `ds` changes.
- `stcp`=1 during cycles 56..57 and 0 otherwise: one pulse per frame, after the 14th `shcp` rise.
- Idle (cycles 60..`SCAN_CYC`-1): `shcp`=0, `stcp`=0, `ds` holds the last bit.
- Reset values: `stcp`=0, `shcp`=0, `ds`=0; all counters 0; shadow registers 0.
- First frame (d=0) begins on the first clock edge after reset deasserts.
- Reset asserted mid-frame: outputs go to 0 immediately and the partial frame is abandoned with no `stcp` pulse. After release, the transfer restarts from d=0, bit 0.
- Latency: a load on cycle n is shown from the next slot start after n.

## Test plan
- Reset then idle (shadow all 0, `SCAN_CYC`=100):
  - Slot d=0 shifts C0 then 000001, i.e. bits 1100_0000_000001.
  - `stcp` is high only on cycles 56–57.
  - Slot d=1 sends C0/000010.
- Load strobe: one-cycle `valid_sd` with num6..num1 = 3,1,1,1,9,0 and `dp`=6'b100010.
  - Slot frames in order: d=0 C0/000001, d=1 10/000010 (9 with DP), d=2 F9/000100, d=3 F9/001000, d=4 F9/010000, d=5 30/100000 (3 with DP).
  - Then wrap to d=0.
- Blink: `twinkle`=6'b000001 with `BLINK_CYC` small (e.g. 600).
  - Digit 1 alternates between its decoded byte and FF at each phase toggle.
  - The other digits are unaffected.
- Hex decode: load all digits with A..F in turn and check the byte for each value against the decode table.
- Mid-frame load: assert `valid_sd` at slot cycle 20.
  - The current frame is unchanged.
  - The next slot uses the new values.
- Reset mid-frame at cycle 30:
  - `shcp`/`stcp`/`ds` go to 0 within the same cycle, with no `stcp` pulse.
  - After release, the frame restarts at d=0 bit 0.

Source files
------------

// File: rtl/sd_itf.sv
// ============================================================================
// sd_itf : serial scan driver for a 6-digit common-anode 7-segment display
//          behind two cascaded 74HC595 shift registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_itf #(
    parameter int SCAN_CYC  = 50000,
    parameter int BLINK_CYC = 25000000
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       valid_sd,
    input  logic [5:0] twinkle,
    input  logic [5:0] dp,
    input  logic [3:0] num6,
    input  logic [3:0] num5,
    input  logic [3:0] num4,
    input  logic [3:0] num3,
    input  logic [3:0] num2,
    input  logic [3:0] num1,
    output logic       stcp,
    output logic       shcp,
    output logic       ds
);

    localparam int C_CW = $clog2(SCAN_CYC);
    localparam int C_BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [C_CW-1:0] C_SLOT_LAST  = C_CW'(SCAN_CYC - 1);
    localparam logic [C_CW-1:0] C_SHIFT_END  = C_CW'(56);
    localparam logic [C_CW-1:0] C_LATCH_A    = C_CW'(56);
    localparam logic [C_CW-1:0] C_LATCH_B    = C_CW'(57);
    localparam logic [C_BW-1:0] C_BLINK_LAST = C_BW'(BLINK_CYC - 1);
    localparam logic [2:0]      C_LAST_DIGIT = 3'd5;

    logic [3:0]      r_num [6];
    logic [5:0]      r_dp;
    logic [5:0]      r_tw;
    logic [C_CW-1:0] r_cnt;
    logic [2:0]      r_digit;
    logic [C_BW-1:0] r_bcnt;
    logic            r_phase;
    logic [12:0]     r_sh;

    logic [3:0]      w_num;
    logic [7:0]      w_seg_raw;
    logic [7:0]      w_seg;
    logic [5:0]      w_sel;
    logic [13:0]     w_frame;

    // Shadow copy of the display contents; the scan only ever reads these.
    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_num[i] <= 4'd0;
            end
            r_dp <= 6'd0;
            r_tw <= 6'd0;
        end else if (valid_sd) begin
            r_num[0] <= num1;
            r_num[1] <= num2;
            r_num[2] <= num3;
            r_num[3] <= num4;
            r_num[4] <= num5;
            r_num[5] <= num6;
            r_dp     <= dp;
            r_tw     <= twinkle;
        end
    end

    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt   <= '0;
            r_digit <= 3'd0;
        end else if (r_cnt == C_SLOT_LAST) begin
            r_cnt   <= '0;
            r_digit <= (r_digit == C_LAST_DIGIT) ? 3'd0 : r_digit + 3'd1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == C_BLINK_LAST) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + 1'b1;
        end
    end

    assign w_num = r_num[r_digit];

    always_comb begin
        w_seg_raw = 8'hFF;
        case (w_num)
            4'h0: w_seg_raw = 8'hC0;
            4'h1: w_seg_raw = 8'hF9;
            4'h2: w_seg_raw = 8'hA4;
            4'h3: w_seg_raw = 8'hB0;
            4'h4: w_seg_raw = 8'h99;
            4'h5: w_seg_raw = 8'h92;
            4'h6: w_seg_raw = 8'h82;
            4'h7: w_seg_raw = 8'hF8;
            4'h8: w_seg_raw = 8'h80;
            4'h9: w_seg_raw = 8'h90;
            4'hA: w_seg_raw = 8'h88;
            4'hB: w_seg_raw = 8'h83;
            4'hC: w_seg_raw = 8'hC6;
            4'hD: w_seg_raw = 8'hA1;
            4'hE: w_seg_raw = 8'h86;
            4'hF: w_seg_raw = 8'h8E;
            default: w_seg_raw = 8'hFF;
        endcase
    end

    // Blanking wins over the decimal point so a blinking digit goes fully dark.
    always_comb begin
        w_seg = w_seg_raw;
        if (r_dp[r_digit]) begin
            w_seg[7] = 1'b0;
        end
        if (r_tw[r_digit] && r_phase) begin
            w_seg = 8'hFF;
        end
    end

    assign w_sel   = 6'(1) << r_digit;
    assign w_frame = {w_seg, w_sel};

    // Frame is captured at slot cycle 0; bit i drives ds for cycles 4i..4i+3
    // with the shift clock high in the second half of each bit.
    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            ds   <= 1'b0;
            shcp <= 1'b0;
            stcp <= 1'b0;
            r_sh <= 13'd0;
        end else begin
            shcp <= (r_cnt < C_SHIFT_END) && r_cnt[1];
            stcp <= (r_cnt == C_LATCH_A) || (r_cnt == C_LATCH_B);
            if (r_cnt == '0) begin
                ds   <= w_frame[13];
                r_sh <= w_frame[12:0];
            end else if ((r_cnt < C_SHIFT_END) && (r_cnt[1:0] == 2'b00)) begin
                ds   <= r_sh[12];
                r_sh <= {r_sh[11:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sd_itf.sv
// ============================================================================
// tb_sd_itf : directed self-checking bench for sd_itf with a frame scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sd_itf;

    localparam int SCAN  = 100;
    localparam int BLINK = 600;

    logic       sysclk   = 1'b0;
    logic       rst      = 1'b1;
    logic       valid_sd = 1'b0;
    logic [5:0] twinkle  = 6'd0;
    logic [5:0] dp       = 6'd0;
    logic [3:0] in_num [6] = '{default: 4'd0};
    logic       stcp, shcp, ds;

    always #5 sysclk = ~sysclk;

    sd_itf #(
        .SCAN_CYC  (SCAN),
        .BLINK_CYC (BLINK)
    ) dut (
        .sysclk   (sysclk),
        .rst_n    (rst),
        .valid_sd (valid_sd),
        .twinkle  (twinkle),
        .dp       (dp),
        .num6     (in_num[5]),
        .num5     (in_num[4]),
        .num4     (in_num[3]),
        .num3     (in_num[2]),
        .num2     (in_num[1]),
        .num1     (in_num[0]),
        .stcp     (stcp),
        .shcp     (shcp),
        .ds       (ds)
    );

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    int pushed   = 0;

    logic [13:0] exp_q [$];

    logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference state of the display contents and the global edge count since reset.
    logic [3:0] m_num [6] = '{default: 4'd0};
    logic [5:0] m_dp = 6'd0;
    logic [5:0] m_tw = 6'd0;
    int         m_k  = 0;

    logic [3:0] p_num [6];
    logic [5:0] p_dp;
    logic [5:0] p_tw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] model_frame(input int d, input int k);
        logic [7:0] seg;
        seg = dec_tab[m_num[d]];
        if (m_dp[d]) seg[7] = 1'b0;
        if (m_tw[d] && (((k / BLINK) % 2) == 1)) seg = 8'hFF;
        return {seg, 6'(1 << d)};
    endfunction

    // Deserialise on every shcp rise and compare on every stcp rise.
    logic [13:0] mon_sh   = 14'd0;
    int          mon_bits = 0;
    logic        p_shcp   = 1'b0;
    logic        p_stcp   = 1'b0;

    always @(posedge sysclk) begin
        #1;
        if (rst) begin
            mon_bits = 0;
            p_shcp   = 1'b0;
            p_stcp   = 1'b0;
        end else begin
            if (shcp && !p_shcp) begin
                mon_sh = {mon_sh[12:0], ds};
                mon_bits++;
            end
            if (stcp && !p_stcp) begin
                chk("bits_per_frame", mon_bits, 14);
                chk("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("frame", mon_sh, exp_q.pop_front());
                mon_bits = 0;
                frames++;
            end
            p_shcp = shcp;
            p_stcp = stcp;
        end
    end

    // One display slot; optional per-cycle pin checks and a load at slot cycle 20.
    task automatic run_slot(input bit timing, input bit load);
        int          d;
        logic [13:0] f;
        d = (m_k / SCAN) % 6;
        f = model_frame(d, m_k);
        exp_q.push_back(f);
        pushed++;
        for (int c = 0; c < SCAN; c++) begin
            @(posedge sysclk);
            #1;
            if (timing) begin
                chk("ds",   ds,   (c < 56) ? f[13 - c / 4] : f[0]);
                chk("shcp", shcp, (c < 56) && ((c % 4) >= 2));
                chk("stcp", stcp, (c == 56) || (c == 57));
            end
            if (load && c == 20) begin
                valid_sd = 1'b1;
                in_num   = p_num;
                dp       = p_dp;
                twinkle  = p_tw;
            end
            if (load && c == 21) begin
                valid_sd = 1'b0;
                m_num    = p_num;
                m_dp     = p_dp;
                m_tw     = p_tw;
            end
        end
        m_k += SCAN;
    endtask

    task automatic run_round(input bit load_last);
        for (int s = 0; s < 6; s++) run_slot(1'b0, load_last && (s == 5));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_ds",   ds,   0);
        chk("reset_shcp", shcp, 0);
        chk("reset_stcp", stcp, 0);
        @(negedge sysclk);
        rst = 1'b0;

        // Idle after reset, with cycle-accurate pin checks on the first two slots.
        run_slot(1'b1, 1'b0);
        run_slot(1'b1, 1'b0);
        run_slot(1'b0, 1'b0);
        run_slot(1'b0, 1'b0);
        run_slot(1'b0, 1'b0);
        p_num = '{4'h0, 4'h9, 4'h1, 4'h1, 4'h1, 4'h3};
        p_dp  = 6'b100010;
        p_tw  = 6'b000000;
        run_slot(1'b0, 1'b1);

        p_num = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        p_dp  = 6'b000000;
        run_round(1'b1);

        p_num = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        run_round(1'b1);

        p_tw = 6'b000001;
        run_round(1'b1);

        // Digit 1 blinks: visible / blank alternates every round of six slots.
        run_slot(1'b1, 1'b0);
        for (int s = 0; s < 5; s++) run_slot(1'b0, 1'b0);
        run_slot(1'b1, 1'b0);
        for (int s = 0; s < 5; s++) run_slot(1'b0, 1'b0);
        run_round(1'b0);
        run_round(1'b0);

        // Reset in the middle of a frame at slot cycle 30.
        for (int c = 0; c <= 30; c++) begin
            @(posedge sysclk);
            #1;
        end
        chk("pre_reset_shcp", shcp, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ds",   ds,   0);
        chk("midrst_shcp", shcp, 0);
        chk("midrst_stcp", stcp, 0);
        for (int c = 0; c < 30; c++) begin
            @(posedge sysclk);
            #1;
            chk("midrst_hold_stcp", stcp, 0);
        end
        @(negedge sysclk);
        rst   = 1'b0;
        m_num = '{default: 4'd0};
        m_dp  = 6'd0;
        m_tw  = 6'd0;
        m_k   = 0;
        run_slot(1'b1, 1'b0);
        run_slot(1'b1, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        chk("frame_count", frames, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
